// File: rtl/loadable_ram_pkg.sv
// Shared types and constants for the loadable RAM: FSM state encoding,
// byte width and the address-width helper.
package loadable_ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/loadable_ram_if.sv
// Request/response bus of the loadable RAM: valid/ready request channel and
// an unbackpressured one-cycle read response.
interface loadable_ram_if import loadable_ram_pkg::*; #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32
) ();
    localparam int ADDR_WIDTH = addr_w(DEPTH);

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_WIDTH-1:0]        req_addr;
    logic [DATA_WIDTH-1:0]        req_wdata;
    logic [DATA_WIDTH/BYTE_W-1:0] req_be;
    logic                         rsp_valid;
    logic [DATA_WIDTH-1:0]        rsp_rdata;
    logic                         rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/loadable_ram_array.sv
// Storage array: one byte-masked write port and a combinational read port.
// Callers must keep both addresses below DEPTH.
module ram_array import loadable_ram_pkg::*; #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wbe_i,
    input  logic [ADDR_WIDTH-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);
    localparam int BE_WIDTH = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (wbe_i[k]) begin
                    mem_q[waddr_i][k*BYTE_W +: BYTE_W] <= wdata_i[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/loadable_ram.sv
// DEPTH x DATA_WIDTH RAM that loads a firmware image (or zeros) after reset
// or reload, then serves byte-masked reads/writes with a registered response.
module loadable_ram import loadable_ram_pkg::*; #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter bit BOOT_LOAD  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DEPTH*DATA_WIDTH-1:0] firmware_data,
    input  logic                        reload,
    output logic                        init_done,
    loadable_ram_if.slave               bus
);
    localparam int ADDR_WIDTH = addr_w(DEPTH);
    localparam int BE_WIDTH   = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                    accept;
    logic                    addr_ok;
    logic                    init_last;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [BE_WIDTH-1:0]     wbe;
    logic [DATA_WIDTH-1:0]   rdata;

    assign addr_ok   = {1'b0, bus.req_addr} < DEPTH_C;
    assign init_last = (idx_q == LAST_IDX);
    assign accept    = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_INIT: begin
                if (init_last) begin
                    state_d = ST_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_READY: begin
                if (reload) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end
            end
        endcase
    end

    // reload wins over a request presented in the same cycle
    always_comb begin
        init_done     = (state_q == ST_READY);
        bus.req_ready = init_done && !reload;
    end

    // Init owns the write port while loading; no array write on a reset edge.
    always_comb begin
        if (state_q == ST_INIT) begin
            we    = !rst;
            waddr = idx_q;
            wdata = BOOT_LOAD ? firmware_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
            wbe   = '1;
        end else begin
            we    = !rst && accept && bus.req_write && addr_ok;
            waddr = bus.req_addr;
            wdata = bus.req_wdata;
            wbe   = bus.req_be;
        end
    end

    ram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .wbe_i   (wbe),
        .raddr_i (bus.req_addr),
        .rdata_o (rdata)
    );

    always_comb begin
        rsp_valid_d = accept && !bus.req_write;
        rsp_err_d   = rsp_valid_d && !addr_ok;
        rsp_rdata_d = (rsp_valid_d && addr_ok) ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_loadable_ram.sv
// Scoreboard bench for loadable_ram: three instances (DEPTH 4/6/8) driven one
// at a time from a shared driver; a monitor checks every read response.
module tb_loadable_ram;
    import loadable_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst_v      = 3'b111;
    logic         drv_valid  = 1'b0;
    logic         drv_write  = 1'b0;
    logic         drv_reload = 1'b0;
    logic [2:0]   drv_addr   = '0;
    logic [31:0]  drv_wdata  = '0;
    logic [3:0]   drv_be     = '0;
    int           sel        = 0;

    logic [127:0] fw_a;
    logic [191:0] fw_b;
    logic [255:0] fw_c;

    logic         done_a, done_b, done_c;
    logic [2:0]   done_v, rv, re, rdy;
    logic [31:0]  rd [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    loadable_ram_if #(.DEPTH(4), .DATA_WIDTH(32)) bus_a ();
    loadable_ram_if #(.DEPTH(6), .DATA_WIDTH(32)) bus_b ();
    loadable_ram_if #(.DEPTH(8), .DATA_WIDTH(32)) bus_c ();

    assign bus_a.req_valid = drv_valid && (sel == 0);
    assign bus_a.req_write = drv_write;
    assign bus_a.req_addr  = drv_addr[1:0];
    assign bus_a.req_wdata = drv_wdata;
    assign bus_a.req_be    = drv_be;
    assign bus_b.req_valid = drv_valid && (sel == 1);
    assign bus_b.req_write = drv_write;
    assign bus_b.req_addr  = drv_addr;
    assign bus_b.req_wdata = drv_wdata;
    assign bus_b.req_be    = drv_be;
    assign bus_c.req_valid = drv_valid && (sel == 2);
    assign bus_c.req_write = drv_write;
    assign bus_c.req_addr  = drv_addr;
    assign bus_c.req_wdata = drv_wdata;
    assign bus_c.req_be    = drv_be;

    loadable_ram #(.DEPTH(4), .DATA_WIDTH(32), .BOOT_LOAD(1'b1)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .firmware_data(fw_a),
        .reload(drv_reload && (sel == 0)), .init_done(done_a), .bus(bus_a)
    );
    loadable_ram #(.DEPTH(6), .DATA_WIDTH(32), .BOOT_LOAD(1'b0)) u_dut_b (
        .clk(clk), .rst(rst_v[1]), .firmware_data(fw_b),
        .reload(drv_reload && (sel == 1)), .init_done(done_b), .bus(bus_b)
    );
    loadable_ram #(.DEPTH(8), .DATA_WIDTH(32), .BOOT_LOAD(1'b1)) u_dut_c (
        .clk(clk), .rst(rst_v[2]), .firmware_data(fw_c),
        .reload(drv_reload && (sel == 2)), .init_done(done_c), .bus(bus_c)
    );

    assign done_v = {done_c, done_b, done_a};
    assign rv     = {bus_c.rsp_valid, bus_b.rsp_valid, bus_a.rsp_valid};
    assign re     = {bus_c.rsp_err, bus_b.rsp_err, bus_a.rsp_err};
    assign rdy    = {bus_c.req_ready, bus_b.req_ready, bus_a.req_ready};
    assign rd[0]  = bus_a.rsp_rdata;
    assign rd[1]  = bus_b.rsp_rdata;
    assign rd[2]  = bus_c.rsp_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest expectation, arriving in
    // the cycle right after its accept edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rv[k]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: dut %0d got data %h with nothing pending", k, rd[k]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_dut", k, e.dut);
                    chk("rsp_rdata", rd[k], e.data);
                    chk("rsp_err", {31'b0, re[k]}, {31'b0, e.err});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_rdata", rd[k], 32'h0);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] ed, input logic ee,
                          input logic er);
        drv_valid = 1'b1;
        drv_write = wr;
        drv_addr  = a;
        drv_wdata = wd;
        drv_be    = be;
        #1;
        chk("req_ready", {31'b0, rdy[sel]}, {31'b0, er});
        if (er && !wr) sb.push_back('{sel, ed, ee, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input logic [2:0] a, input logic [31:0] ed, input logic ee);
        do_req(1'b0, a, 32'h0, 4'h0, ed, ee, 1'b1);
    endtask

    task automatic wr_req(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        do_req(1'b1, a, wd, be, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        drv_valid = 1'b0;
        drv_write = 1'b0;
    endtask

    // Called just after an edge that leaves the DUT in INIT: init_done stays
    // low for n sampled cycles and then rises.
    task automatic wait_init(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("init_busy", {31'b0, done_v[k]}, 32'h0);
        end
        @(negedge clk);
        chk("init_done", {31'b0, done_v[k]}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        fw_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        fw_b = '1;
        for (int i = 0; i < 8; i++) fw_c[i*32 +: 32] = 32'hC0DE0000 + 32'(i);

        // DEPTH=4 boot load, byte enables, reload
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        wait_init(0, 4);
        rd_req(3'd0, 32'h11111111, 1'b0);
        rd_req(3'd1, 32'h22222222, 1'b0);
        rd_req(3'd2, 32'h33333333, 1'b0);
        rd_req(3'd3, 32'h44444444, 1'b0);
        wr_req(3'd2, 32'hAABBCCDD, 4'b0101);
        rd_req(3'd2, 32'h33BB33DD, 1'b0);
        wr_req(3'd0, 32'hDEADBEEF, 4'hF);
        rd_req(3'd0, 32'hDEADBEEF, 1'b0);
        rd_req(3'd1, 32'h22222222, 1'b0);
        chk("done_before_reload", {31'b0, done_v[0]}, 32'h1);
        drv_reload = 1'b1;
        do_req(1'b1, 3'd0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b0);
        drv_reload = 1'b0;
        idle();
        wait_init(0, 4);
        rd_req(3'd0, 32'h11111111, 1'b0);
        rd_req(3'd2, 32'h33333333, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // DEPTH=6 zero init, out-of-range accesses, empty byte mask
        sel = 1;
        rst_v[1] = 1'b0;
        wait_init(1, 6);
        for (int i = 0; i < 6; i++) rd_req(3'(i), 32'h0, 1'b0);
        rd_req(3'd7, 32'h0, 1'b1);
        wr_req(3'd5, 32'h55AA55AA, 4'hF);
        wr_req(3'd6, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 5; i++) rd_req(3'(i), 32'h0, 1'b0);
        rd_req(3'd5, 32'h55AA55AA, 1'b0);
        rd_req(3'd6, 32'h0, 1'b1);
        wr_req(3'd3, 32'h12345678, 4'h0);
        rd_req(3'd3, 32'h0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // DEPTH=8 reset while idx=5, then full init
        sel = 2;
        rst_v[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_v[2]  = 1'b1;
        drv_valid = 1'b1;
        drv_write = 1'b0;
        drv_addr  = 3'd1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_init_done", {31'b0, done_v[2]}, 32'h0);
            chk("rst_req_ready", {31'b0, rdy[2]}, 32'h0);
            chk("rst_rsp_valid", {31'b0, rv[2]}, 32'h0);
            chk("rst_rsp_err", {31'b0, re[2]}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_v[2] = 1'b0;
        idle();
        wait_init(2, 8);
        rd_req(3'd0, 32'hC0DE0000, 1'b0);
        rd_req(3'd5, 32'hC0DE0005, 1'b0);
        rd_req(3'd7, 32'hC0DE0007, 1'b0);
        idle();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
